out_i2s: RTL and testbench
==========================

OUT_I2S -- requirements
Module: out_i2s

Interface
REQ-001 Parameter DATA_WIDTH, default 24, sets bits per channel; one frame is 2*DATA_WIDTH BCLK cycles.
REQ-002 BCLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 enable  in  1  level; high = transmit frames continuously; low = stop at the next frame boundary.
REQ-005 sample_valid  in  1  upstream offers a stereo sample on left_data/right_data.
REQ-006 left_data  in  DATA_WIDTH  left channel sample, two's complement, MSB first on the wire.
REQ-007 right_data  in  DATA_WIDTH  right channel sample, same format.
REQ-008 sample_ready  out  1  the pending buffer is empty and can accept a sample.
REQ-009 DACDAT  out  1  serial data to the codec, registered.
REQ-010 DACLRC  out  1  channel select, registered; 0 = left, 1 = right.
REQ-011 frame_done  out  1  one-cycle pulse after the last bit of a frame is driven.
REQ-012 underrun  out  1  one-cycle pulse when a frame starts with no pending sample.

Function
REQ-013 Storage: one pending register pair (left, right, full flag) plus one active shift register pair.
REQ-014 Handshake: a sample is accepted on a rising edge with sample_valid=1 and sample_ready=1; sample_ready = !pending_full.
REQ-015 Acceptance is allowed in IDLE and RUN (prefill permitted); data offered while sample_ready=0 is ignored, not queued.
REQ-016 States: IDLE and RUN; 6-bit bit counter k, range 0..2*DATA_WIDTH-1.
REQ-017 IDLE -> RUN on a rising edge with enable=1; that same edge performs the frame load (REQ-019) and drives bit k=0.
REQ-018 In RUN, k increments each edge; from k=2*DATA_WIDTH-1 it wraps to 0 and loads the next frame if enable=1, else goes to IDLE.
REQ-019 Frame load: if pending_full, copy pending to active and clear pending_full; else load zeros into active and pulse underrun.
REQ-020 An accept and a frame load on the same edge cannot involve the same sample; when pending was empty at load, the newly accepted sample becomes pending for the next frame.
REQ-021 Output after the edge driving bit k: DACLRC = (k >= DATA_WIDTH).
REQ-022 Output after the edge driving bit k: DACDAT = left[DATA_WIDTH-1-k] for k < DATA_WIDTH, else right[2*DATA_WIDTH-1-k].
REQ-023 Framing matches the capture stage (left first, MSB first, no one-bit delay) so a loopback reproduces the samples exactly.
REQ-024 frame_done is high for the cycle following the edge that drove k=2*DATA_WIDTH-1, whether the next state is RUN or IDLE.
REQ-025 In IDLE: DACDAT=0, DACLRC=0, k=0; the pending contents are retained.
REQ-026 enable deasserted mid-frame does not truncate the frame; enable re-asserted before the last bit gives a seamless next frame.

Reset
REQ-027 While RESET_N=0, regardless of clock: state=IDLE, k=0, pending_full=0, active=0, DACDAT=0, DACLRC=0, sample_ready=1, frame_done=0, underrun=0.
REQ-028 Reset mid-frame aborts the frame immediately and discards the pending sample; the first edge after release follows REQ-017.

Verification
REQ-029 Prefill left=0xA5A5A5, right=0x3C3C3C in IDLE, then enable=1 -> 48 bits: 101001011010010110100101 with DACLRC=0, then 001111000011110000111100 with DACLRC=1; frame_done pulses once; no underrun.
REQ-030 enable=1 with no sample offered -> underrun pulses on the load edge of every frame; DACDAT stays 0; DACLRC toggles every 24 cycles.
REQ-031 Offer 0x800001/0x7FFFFF while pending is full -> sample_ready=0 and the sample is ignored; re-offered after the load edge, it is accepted and transmitted in the following frame.
REQ-032 Drop enable at k=10 -> the frame completes to k=47, frame_done pulses, then the block enters IDLE with DACDAT=0 and DACLRC=0.
REQ-033 Assert RESET_N=0 at k=30 without waiting for a clock edge -> outputs take reset values at once; sample_ready=1; the next enable starts at k=0 with underrun.
REQ-034 Loopback into the capture stage for 4 consecutive frames with distinct samples -> every captured left/right word equals the transmitted word.

Source files
------------

// File: rtl/out_i2s.sv
// ---------------------------------------------------------------------------
// out_i2s : I2S-style serial transmitter for a stereo DAC.
//
// Sends frames of 2*DATA_WIDTH bits, left channel first, MSB first, with no
// one-bit delay after the DACLRC change. One stereo sample can be buffered
// (pending) while the current frame shifts out of the active register. When
// no sample is waiting at a frame boundary, the block sends a zero frame and
// reports an underrun.
//
// Ports
//   BCLK          in   bit clock; all state changes on its rising edge
//   RESET_N       in   asynchronous active-low reset
//   enable        in   high: send frames back to back; low: stop at the end
//                      of the current frame
//   sample_valid  in   upstream offers left_data/right_data
//   left_data     in   left sample, two's complement
//   right_data    in   right sample, two's complement
//   sample_ready  out  pending buffer is empty (a sample is accepted on
//                      valid && ready)
//   DACDAT        out  serial data, registered
//   DACLRC        out  channel select, registered (0 = left, 1 = right)
//   frame_done    out  high while the last bit of a frame is on DACDAT
//   underrun      out  one-cycle pulse when a frame starts with no sample
// ---------------------------------------------------------------------------
module out_i2s #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  BCLK,
    input  logic                  RESET_N,
    input  logic                  enable,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_ready,
    output logic                  DACDAT,
    output logic                  DACLRC,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam int         FRAME_BITS = 2 * DATA_WIDTH;
    localparam logic [5:0] K_LAST     = 6'(FRAME_BITS - 1);
    localparam logic [5:0] K_RIGHT    = 6'(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              k_q, k_d;
    logic                    pend_full_q, pend_full_d;
    logic [DATA_WIDTH-1:0]   pend_l_q, pend_l_d;
    logic [DATA_WIDTH-1:0]   pend_r_q, pend_r_d;
    // Active left/right pair held as one word so the wire order is simply
    // the MSB of the concatenation.
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    dacdat_q, dacdat_d;
    logic                    daclrc_q, daclrc_d;
    logic                    frame_done_q, frame_done_d;
    logic                    underrun_q, underrun_d;

    logic                    accept;
    logic                    last_bit;
    logic                    load;
    logic [FRAME_BITS-1:0]   frame_word;

    assign accept     = sample_valid && !pend_full_q;
    assign last_bit   = (state_q == ST_RUN) && (k_q == K_LAST);
    // A frame starts either from IDLE or seamlessly after the last bit.
    assign load       = enable && ((state_q == ST_IDLE) || last_bit);
    assign frame_word = pend_full_q ? {pend_l_q, pend_r_q} : '0;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        k_d          = k_q;
        shift_d      = shift_q;
        pend_full_d  = pend_full_q;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        dacdat_d     = dacdat_q;
        daclrc_d     = daclrc_q;
        underrun_d   = 1'b0;

        if (load) begin
            // Bit 0 of the new frame goes out on the same edge as the load.
            state_d     = ST_RUN;
            k_d         = '0;
            dacdat_d    = frame_word[FRAME_BITS-1];
            shift_d     = frame_word << 1;
            daclrc_d    = 1'b0;
            underrun_d  = !pend_full_q;
            pend_full_d = 1'b0;
        end else if (last_bit) begin
            state_d  = ST_IDLE;
            k_d      = '0;
            shift_d  = '0;
            dacdat_d = 1'b0;
            daclrc_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            k_d      = k_q + 6'd1;
            dacdat_d = shift_q[FRAME_BITS-1];
            shift_d  = shift_q << 1;
            daclrc_d = (k_d >= K_RIGHT);
        end

        frame_done_d = (state_d == ST_RUN) && (k_d == K_LAST);

        // Accept only ever fills an empty buffer, so it cannot collide with
        // a load that consumes a sample; after a zero-frame load the new
        // sample waits for the next frame.
        if (accept) begin
            pend_l_d    = left_data;
            pend_r_d    = right_data;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge BCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: the sample registers are cleared as well, so a reset
            // discards any buffered audio rather than only the flag.
            state_q      <= ST_IDLE;
            k_q          <= '0;
            shift_q      <= '0;
            pend_full_q  <= 1'b0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            dacdat_q     <= 1'b0;
            daclrc_q     <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from
            // the values present before the edge.
            state_q      <= state_d;
            k_q          <= k_d;
            shift_q      <= shift_d;
            pend_full_q  <= pend_full_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            dacdat_q     <= dacdat_d;
            daclrc_q     <= daclrc_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sample_ready = !pend_full_q;
    assign DACDAT       = dacdat_q;
    assign DACLRC       = daclrc_q;
    assign frame_done   = frame_done_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_out_i2s.sv
// ---------------------------------------------------------------------------
// tb_out_i2s : directed self-checking bench for out_i2s (DATA_WIDTH = 24).
// Expected frames are written out by hand; a small capture stage in the bench
// deserialises DACDAT/DACLRC to confirm samples survive a loopback.
// ---------------------------------------------------------------------------
module tb_out_i2s;

    logic        BCLK;
    logic        RESET_N;
    logic        enable;
    logic        sample_valid;
    logic [23:0] left_data;
    logic [23:0] right_data;
    logic        sample_ready;
    logic        DACDAT;
    logic        DACLRC;
    logic        frame_done;
    logic        underrun;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] ready_log;

    // Capture stage: left bits while DACLRC=0, right bits while DACLRC=1.
    bit          cap_on = 1'b0;
    logic [23:0] cap_l;
    logic [23:0] cap_r;
    logic [47:0] cap_q[$];

    logic [47:0] lb_s[5];

    out_i2s #(.DATA_WIDTH(24)) dut (
        .BCLK         (BCLK),
        .RESET_N      (RESET_N),
        .enable       (enable),
        .sample_valid (sample_valid),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_ready (sample_ready),
        .DACDAT       (DACDAT),
        .DACLRC       (DACLRC),
        .frame_done   (frame_done),
        .underrun     (underrun)
    );

    initial begin
        BCLK = 1'b0;
        forever #5 BCLK = ~BCLK;
    end

    always @(negedge BCLK) begin
        if (cap_on) begin
            if (DACLRC) cap_r = {cap_r[22:0], DACDAT};
            else        cap_l = {cap_l[22:0], DACDAT};
            if (frame_done) cap_q.push_back({cap_l, cap_r});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge BCLK);
        #1;
    endtask

    task automatic offer(input logic [47:0] s);
        sample_valid = 1'b1;
        left_data    = s[47:24];
        right_data   = s[23:0];
    endtask

    // Runs one whole frame (48 edges, the first being the load edge) and
    // checks its bits, channel select, frame_done position and underruns.
    // After the edge that drove bit p, the optional stimulus for the next
    // edge is applied.
    task automatic run_frame(input string tag, input logic [47:0] exp_bits,
                             input int exp_ur, input int drop_en_at,
                             input int von_at, input int voff_at,
                             input logic [47:0] vs);
        logic [47:0] bits;
        int fd_n    = 0;
        int fd_pos  = -1;
        int ur_n    = 0;
        int lrc_bad = 0;
        for (int p = 0; p < 48; p++) begin
            tick();
            bits[47-p]   = DACDAT;
            ready_log[p] = sample_ready;
            if (DACLRC !== ((p >= 24) ? 1'b1 : 1'b0)) lrc_bad++;
            if (frame_done === 1'b1) begin
                fd_n++;
                fd_pos = p;
            end
            if (underrun === 1'b1) ur_n++;
            if (p == von_at)     offer(vs);
            if (p == voff_at)    sample_valid = 1'b0;
            if (p == drop_en_at) enable = 1'b0;
        end
        check({tag, "_bits"},   bits,    exp_bits);
        check({tag, "_lrc"},    lrc_bad, 0);
        check({tag, "_fd_n"},   fd_n,    1);
        check({tag, "_fd_pos"}, fd_pos,  47);
        check({tag, "_ur"},     ur_n,    exp_ur);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dat"}, DACDAT,     1'b0);
        check({tag, "_lrc"}, DACLRC,     1'b0);
        check({tag, "_fd"},  frame_done, 1'b0);
    endtask

    initial begin
        RESET_N      = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        left_data    = '0;
        right_data   = '0;
        lb_s[0] = {24'h800000, 24'h7FFFFF};
        lb_s[1] = {24'hDEADBE, 24'h012345};
        lb_s[2] = {24'h0F0F0F, 24'hF0F0F0};
        lb_s[3] = {24'hFFFFFF, 24'h000001};
        lb_s[4] = '0;

        // Reset values.
        repeat (2) tick();
        check("rst0_ready", sample_ready, 1'b1);
        check("rst0_ur",    underrun,     1'b0);
        check_idle("rst0");
        RESET_N = 1'b1;
        tick();

        // Prefill in IDLE, then one frame; enable dropped right after load.
        offer({24'hA5A5A5, 24'h3C3C3C});
        tick();
        sample_valid = 1'b0;
        check("prefill_ready", sample_ready, 1'b0);
        enable = 1'b1;
        run_frame("f_a5", {24'b101001011010010110100101, 24'b001111000011110000111100},
                  0, 0, -1, -1, '0);
        check("f_a5_ready0", ready_log[0], 1'b1);
        tick();
        check_idle("idle_a5");
        tick();
        check_idle("idle_a5b");

        // Continuous underrun: zero frames, underrun at each load.
        enable = 1'b1;
        run_frame("uf0", '0, 1, -1, -1, -1, '0);
        run_frame("uf1", '0, 1, -1, -1, -1, '0);

        // Sample offered on a zero-frame load edge waits for the next frame;
        // 0x800001/0x7FFFFF offered while full is ignored.
        offer({24'h123456, 24'h654321});
        run_frame("f_load_acc", '0, 1, -1, 5, 9, {24'h800001, 24'h7FFFFF});
        check("full_ready", ready_log, 48'h0);
        // Re-offer after the load edge: accepted, sent next frame.
        run_frame("f_123", {24'h123456, 24'h654321}, 0, -1, 0, 1,
                  {24'h800001, 24'h7FFFFF});
        check("reoffer_ready", {ready_log[1], ready_log[0]}, 2'b01);
        // Enable dropped at k=10: frame still completes.
        run_frame("f_800", {24'h800001, 24'h7FFFFF}, 0, 10, -1, -1, '0);
        tick();
        check_idle("idle_drop");
        check("idle_drop_ready", sample_ready, 1'b1);

        // Asynchronous reset at k=30 with a sample buffered.
        offer({24'h000000, 24'hFFFFFF});
        tick();
        sample_valid = 1'b0;
        enable = 1'b1;
        repeat (31) tick();
        check("pre_rst_out", {DACLRC, DACDAT}, 2'b11);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_dat",   DACDAT,       1'b0);
        check("arst_lrc",   DACLRC,       1'b0);
        check("arst_ready", sample_ready, 1'b1);
        check("arst_fd",    frame_done,   1'b0);
        check("arst_ur",    underrun,     1'b0);
        tick();
        check_idle("rst_hold");
        RESET_N = 1'b1;
        run_frame("f_after_rst", '0, 1, 0, -1, -1, '0);
        tick();
        check_idle("idle_rst");

        // Loopback of four consecutive frames through the capture stage.
        offer(lb_s[0]);
        tick();
        sample_valid = 1'b0;
        cap_on = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("lb%0d", i), lb_s[i], 0,
                      (i == 3) ? 5 : -1, (i < 3) ? 2 : -1, 3, lb_s[i+1]);
        end
        tick();
        check("lb_count", cap_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_q.size()) check($sformatf("lb_cap%0d", i), cap_q[i], lb_s[i]);
        end
        check_idle("idle_lb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
